// File: rtl/rx_frame_delimiter.sv
// Receive framer: hunts preamble/SFD, strips them and forwards frame bytes with
// SOF/EOF, length/dribble error and destination-address match at EOF.
module rx_frame_delimiter #(
  parameter int unsigned MIN_PREAMBLE = 1,
  parameter int unsigned MIN_LEN      = 64,
  parameter int unsigned MAX_LEN      = 1518,
  parameter logic [47:0] DEST_MAC     = 48'h02_00_00_00_00_01,
  parameter bit          PROMISC      = 1'b0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        rx_data_valid,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  // Stream is PHY-paced with no ready: frame_data is consumed on every cycle
  // frame_valid is high; sof/eof/err/len/addr_match qualify that same beat.
  output logic [7:0]  frame_data,
  output logic        frame_valid,
  output logic        frame_sof,
  output logic        frame_eof,
  output logic        frame_err,
  output logic [10:0] frame_len,
  output logic        addr_match,
  output logic [1:0]  fsm_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PRE  = 2'd1;
  localparam logic [1:0] S_BODY = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  localparam logic [7:0]  MIN_PRE_L = 8'(MIN_PREAMBLE);
  localparam logic [10:0] MIN_LEN_L = 11'(MIN_LEN);
  localparam logic [10:0] MAX_LEN_L = 11'(MAX_LEN);

  logic [1:0]  state;
  logic        rx_dv_q;
  logic        parity;
  logic [7:0]  pcnt;
  logic [10:0] len;
  logic [7:0]  hold;
  logic        have_hold;
  logic        sof_pend;
  logic        dest_eq;
  logic        bcast_eq;
  logic        end_evt;
  logic [47:0] mac_shift;
  logic [7:0]  mac_byte;

  assign fsm_state = state;
  assign end_evt   = !rx_data_valid && !byte_valid;

  // Station address byte expected at body position len (valid while len < 6).
  always_comb begin
    mac_shift = DEST_MAC << {len[2:0], 3'b000};
    mac_byte  = mac_shift[47:40];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      rx_dv_q     <= 1'b1;  // a live envelope at release is never taken as a rise
      parity      <= 1'b0;
      pcnt        <= '0;
      len         <= '0;
      hold        <= '0;
      have_hold   <= 1'b0;
      sof_pend    <= 1'b0;
      dest_eq     <= 1'b0;
      bcast_eq    <= 1'b0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      frame_sof   <= 1'b0;
      frame_eof   <= 1'b0;
      frame_err   <= 1'b0;
      frame_len   <= '0;
      addr_match  <= 1'b0;
    end else begin
      rx_dv_q     <= rx_data_valid;
      frame_valid <= 1'b0;
      frame_sof   <= 1'b0;
      frame_eof   <= 1'b0;
      frame_err   <= 1'b0;
      frame_len   <= '0;
      addr_match  <= 1'b0;
      if (state != S_IDLE && rx_data_valid) parity <= ~parity;

      case (state)
        S_IDLE: begin
          if (rx_data_valid) begin
            parity <= 1'b1;  // the rising cycle carries the first nibble
            pcnt   <= '0;
            state  <= rx_dv_q ? S_DROP : S_PRE;
          end
        end
        S_PRE: begin
          if (byte_valid) begin
            if (byte_in == 8'h55) begin
              if (pcnt != 8'hFF) pcnt <= pcnt + 8'd1;
            end else if (byte_in == 8'hD5 && pcnt >= MIN_PRE_L) begin
              state     <= S_BODY;
              len       <= '0;
              have_hold <= 1'b0;
              sof_pend  <= 1'b1;
              dest_eq   <= 1'b1;
              bcast_eq  <= 1'b1;
            end else begin
              state <= S_DROP;
            end
          end else if (end_evt) begin
            state <= S_IDLE;
          end
        end
        S_BODY: begin
          if (byte_valid) begin
            if (have_hold) begin
              frame_valid <= 1'b1;
              frame_data  <= hold;
              frame_sof   <= sof_pend;
              sof_pend    <= 1'b0;
            end
            hold      <= byte_in;
            have_hold <= 1'b1;
            if (len != 11'h7FF) len <= len + 11'd1;
            if (len < 11'd6) begin
              if (byte_in != mac_byte) dest_eq  <= 1'b0;
              if (byte_in != 8'hFF)    bcast_eq <= 1'b0;
            end
          end else if (end_evt) begin
            if (have_hold) begin
              frame_valid <= 1'b1;
              frame_data  <= hold;
              frame_sof   <= sof_pend;
              frame_eof   <= 1'b1;
              frame_err   <= (len < MIN_LEN_L) || (len > MAX_LEN_L) || parity;
              frame_len   <= len;
              addr_match  <= PROMISC || ((len >= 11'd6) && (dest_eq || bcast_eq));
            end
            have_hold <= 1'b0;
            sof_pend  <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          if (end_evt) state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_frame_delimiter.sv
// Directed bench for rx_frame_delimiter: nibble-paced frames, byte scoreboard,
// end-of-frame field checks, drop and mid-frame reset cases.
module tb_rx_frame_delimiter;

  logic        clock;
  logic        reset_n;
  logic        rx_data_valid;
  logic        byte_valid;
  logic [7:0]  byte_in;
  logic [7:0]  frame_data;
  logic        frame_valid;
  logic        frame_sof;
  logic        frame_eof;
  logic        frame_err;
  logic [10:0] frame_len;
  logic        addr_match;
  logic [1:0]  fsm_state;

  localparam logic [47:0] MY_MAC = 48'h02_00_00_00_00_01;
  localparam logic [47:0] BC_MAC = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] OT_MAC = 48'h02_00_00_00_00_02;

  rx_frame_delimiter dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .rx_data_valid (rx_data_valid),
    .byte_valid    (byte_valid),
    .byte_in       (byte_in),
    .frame_data    (frame_data),
    .frame_valid   (frame_valid),
    .frame_sof     (frame_sof),
    .frame_eof     (frame_eof),
    .frame_err     (frame_err),
    .frame_len     (frame_len),
    .addr_match    (addr_match),
    .fsm_state     (fsm_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0]  exp_q[$];
  int          valid_cnt;
  int          eof_cnt;
  logic [10:0] eof_len;
  logic        eof_err;
  logic        eof_match;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] body_byte(input logic [47:0] dest, input int j);
    logic [47:0] s;
    if (j < 6) begin
      s = dest << (8 * j);
      return s[47:40];
    end
    return 8'(j * 7 + 3);
  endfunction

  // scoreboard / monitor
  always @(negedge clock) begin
    if (reset_n && frame_valid) begin
      check("sof", 32'(frame_sof), 32'(valid_cnt == 0));
      valid_cnt++;
      check("out_queued", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("data", 32'(frame_data), 32'(exp_q.pop_front()));
      if (frame_eof) begin
        eof_cnt++;
        eof_len   = frame_len;
        eof_err   = frame_err;
        eof_match = addr_match;
      end
    end
  end

  // drivers
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      rx_data_valid = 1'b0;
      byte_valid    = 1'b0;
      byte_in       = 8'h00;
    end
  endtask

  // One frame on the nibble clock: two rx_data_valid cycles per byte, byte strobe
  // after its second nibble (the last one lands on the cycle rx_data_valid falls).
  task automatic send_frame(input int n_pre, input logic [7:0] sfd, input int n_body,
                            input logic [47:0] dest, input bit extra, input bit expect_out,
                            input int rst_idx);
    int nb      = n_pre + 1 + n_body;
    int nnib    = 2 * nb + (extra ? 1 : 0);
    int rst_cyc = (rst_idx >= 0) ? 2 * (n_pre + 1 + rst_idx + 1) + 1 : -1;
    bit live    = expect_out;
    valid_cnt = 0;
    eof_cnt   = 0;
    for (int c = 0; c <= 2 * nb + 1; c++) begin
      @(posedge clock); #1;
      if (c == rst_cyc) begin
        check("pre_reset_valid", 32'(frame_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst_valid", 32'(frame_valid), 32'd0);
        check("rst_data", 32'(frame_data), 32'd0);
        check("rst_state", 32'(fsm_state), 32'd0);
        exp_q.delete();
        live = 1'b0;
      end
      if (rst_cyc >= 0 && c == rst_cyc + 6) reset_n = 1'b1;
      if (rst_cyc >= 0 && c == rst_cyc + 9) check("release_drop", 32'(fsm_state), 32'd3);
      rx_data_valid = (c < nnib);
      byte_valid    = (c >= 2) && (c % 2 == 0);
      byte_in       = 8'h00;
      if (byte_valid) begin
        int k;
        k = c / 2 - 1;
        if (k < n_pre)       byte_in = 8'h55;
        else if (k == n_pre) byte_in = sfd;
        else begin
          byte_in = body_byte(dest, k - n_pre - 1);
          if (live) exp_q.push_back(byte_in);
        end
      end
    end
    idle(4);
  endtask

  task automatic check_frame(input string tag, input int exp_valid, input bit exp_eof,
                             input int len, input bit err, input bit match);
    check({tag, "_valid_cnt"}, 32'(valid_cnt), 32'(exp_valid));
    check({tag, "_eof_cnt"}, 32'(eof_cnt), exp_eof ? 32'd1 : 32'd0);
    check({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_idle"}, 32'(fsm_state), 32'd0);
    if (exp_eof) begin
      check({tag, "_len"}, 32'(eof_len), 32'(len));
      check({tag, "_err"}, 32'(eof_err), 32'(err));
      check({tag, "_match"}, 32'(eof_match), 32'(match));
    end
  endtask

  initial begin
    reset_n       = 1'b0;
    rx_data_valid = 1'b0;
    byte_valid    = 1'b0;
    byte_in       = 8'h00;
    valid_cnt     = 0;
    eof_cnt       = 0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_valid", 32'(frame_valid), 32'd0);
    check("reset_eof", 32'(frame_eof), 32'd0);
    check("reset_data", 32'(frame_data), 32'd0);
    check("reset_len", 32'(frame_len), 32'd0);
    check("reset_match", 32'(addr_match), 32'd0);
    check("reset_state", 32'(fsm_state), 32'd0);
    reset_n = 1'b1;
    idle(2);

    send_frame(7, 8'hD5, 64, MY_MAC, 1'b0, 1'b1, -1);
    check_frame("own64", 64, 1'b1, 64, 1'b0, 1'b1);

    send_frame(7, 8'hD5, 64, BC_MAC, 1'b0, 1'b1, -1);
    check_frame("bcast64", 64, 1'b1, 64, 1'b0, 1'b1);

    send_frame(7, 8'hD5, 64, OT_MAC, 1'b0, 1'b1, -1);
    check_frame("other64", 64, 1'b1, 64, 1'b0, 1'b0);

    send_frame(7, 8'hD5, 63, MY_MAC, 1'b0, 1'b1, -1);
    check_frame("short63", 63, 1'b1, 63, 1'b1, 1'b1);

    send_frame(1, 8'hD5, 1518, MY_MAC, 1'b0, 1'b1, -1);
    check_frame("max1518", 1518, 1'b1, 1518, 1'b0, 1'b1);

    send_frame(1, 8'hD5, 1519, MY_MAC, 1'b0, 1'b1, -1);
    check_frame("long1519", 1519, 1'b1, 1519, 1'b1, 1'b1);

    send_frame(7, 8'hD5, 64, MY_MAC, 1'b1, 1'b1, -1);
    check_frame("dribble", 64, 1'b1, 64, 1'b1, 1'b1);

    send_frame(1, 8'hD5, 1, MY_MAC, 1'b0, 1'b1, -1);
    check_frame("single", 1, 1'b1, 1, 1'b1, 1'b0);

    send_frame(2, 8'hAA, 64, MY_MAC, 1'b0, 1'b0, -1);
    check_frame("bad_sfd", 0, 1'b0, 0, 1'b0, 1'b0);

    send_frame(0, 8'hD5, 64, MY_MAC, 1'b0, 1'b0, -1);
    check_frame("no_preamble", 0, 1'b0, 0, 1'b0, 1'b0);

    send_frame(7, 8'hD5, 64, MY_MAC, 1'b0, 1'b1, -1);
    check_frame("after_drop", 64, 1'b1, 64, 1'b0, 1'b1);

    send_frame(7, 8'hD5, 64, MY_MAC, 1'b0, 1'b1, 20);
    check_frame("mid_reset", 19, 1'b0, 0, 1'b0, 1'b0);

    send_frame(7, 8'hD5, 65, BC_MAC, 1'b0, 1'b1, -1);
    check_frame("after_reset", 65, 1'b1, 65, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
